// File: rtl/img_2col_gemm_pkg.sv
// Shared widths, FSM state encoding and the window-fit helper for the
// im2col-style convolution engine.
package img_2col_gemm_pkg;

    localparam int TENSOR_SIZE      = 8;
    localparam int KERNEL_SIZE      = 8;
    localparam int CHANNELS_SIZE    = 8;
    localparam int STRIDE_SIZE      = 8;
    localparam int KERNEL_NUMS_SIZE = 8;
    localparam int RESULT_SIZE      = 32;
    localparam int DATA_SIZE        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // True when the window origin can advance one stride and the window still fits.
    // Two guard bits keep origin+stride+kernel from wrapping.
    function automatic logic origin_can_step(
        input logic [TENSOR_SIZE-1:0] origin,
        input logic [STRIDE_SIZE-1:0] step,
        input logic [KERNEL_SIZE-1:0] kern,
        input logic [TENSOR_SIZE-1:0] tsize
    );
        logic [TENSOR_SIZE+1:0] reach;
        reach = (TENSOR_SIZE+2)'(origin) + (TENSOR_SIZE+2)'(step) + (TENSOR_SIZE+2)'(kern);
        return reach <= (TENSOR_SIZE+2)'(tsize);
    endfunction

endpackage

// File: rtl/img_2col_gemm_rom.sv
// Synchronous-read ROM with a registered output; contents are preloaded by the
// surrounding flow and are never touched by reset.
module img2col_rom #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // rd_en doubles as the stall: a frozen engine must see a frozen data word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/img_2col_gemm.sv
// Convolution as a stream of dot products: walks kernels, output rows, output
// columns and taps, feeding a 3-stage read/multiply/accumulate pipeline.
module img_2col_gemm #(
    parameter int FMAP_DEPTH = 4096,
    parameter int WGT_DEPTH  = 4096,
    parameter int DATA_SIZE  = 8
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic                                           enable,
    input  logic [img_2col_gemm_pkg::TENSOR_SIZE-1:0]      tensor_size,
    input  logic [img_2col_gemm_pkg::KERNEL_SIZE-1:0]      kernel_size,
    input  logic [img_2col_gemm_pkg::CHANNELS_SIZE-1:0]    channels,
    input  logic [img_2col_gemm_pkg::STRIDE_SIZE-1:0]      stride,
    input  logic [img_2col_gemm_pkg::KERNEL_NUMS_SIZE-1:0] kernel_nums,
    output logic [img_2col_gemm_pkg::RESULT_SIZE-1:0]      o_result,
    output logic                                           w_done,
    output logic [img_2col_gemm_pkg::RESULT_SIZE-1:0]      dout
);
    import img_2col_gemm_pkg::*;

    localparam int FA_W = $clog2(FMAP_DEPTH);
    localparam int WA_W = $clog2(WGT_DEPTH);
    localparam int PW   = 2 * DATA_SIZE;

    state_e state_q, state_d;

    logic [TENSOR_SIZE-1:0]      t_q, t_d;
    logic [KERNEL_SIZE-1:0]      k_q, k_d;
    logic [CHANNELS_SIZE-1:0]    c_q, c_d;
    logic [STRIDE_SIZE-1:0]      s_q, s_d;
    logic [KERNEL_NUMS_SIZE-1:0] n_q, n_d;

    logic [KERNEL_NUMS_SIZE-1:0] kn_q, kn_d;
    logic [TENSOR_SIZE-1:0]      oy_q, oy_d;
    logic [TENSOR_SIZE-1:0]      ox_q, ox_d;
    logic [CHANNELS_SIZE-1:0]    ch_q, ch_d;
    logic [KERNEL_SIZE-1:0]      ky_q, ky_d;
    logic [KERNEL_SIZE-1:0]      kx_q, kx_d;

    logic rd_v_q, rd_v_d, rd_first_q, rd_first_d, rd_last_q, rd_last_d;
    logic mul_v_q, mul_v_d, mul_first_q, mul_first_d, mul_last_q, mul_last_d;
    logic acc_last_q, acc_last_d;
    logic w_done_q, w_done_d;
    logic [RESULT_SIZE-1:0] prod_q, prod_d;
    logic [RESULT_SIZE-1:0] acc_q, acc_d;
    logic [RESULT_SIZE-1:0] o_result_q, o_result_d;

    logic [FA_W-1:0]      fmap_addr;
    logic [WA_W-1:0]      wgt_addr;
    logic [DATA_SIZE-1:0] fmap_data, wgt_data;
    logic signed [PW-1:0] fmap_ext, wgt_ext, prod_raw;
    logic degenerate, tap_first;
    logic kx_end, ky_end, ch_end, ox_end, oy_end, kn_end;

    // Origins are the window's top-left corner; the tap offset is added here.
    assign fmap_addr = FA_W'(32'(ch_q) * 32'(t_q) * 32'(t_q)
                           + 32'(oy_q + TENSOR_SIZE'(ky_q)) * 32'(t_q)
                           + 32'(ox_q + TENSOR_SIZE'(kx_q)));
    assign wgt_addr  = WA_W'(32'(kn_q) * 32'(c_q) * 32'(k_q) * 32'(k_q)
                           + 32'(ch_q) * 32'(k_q) * 32'(k_q)
                           + 32'(ky_q) * 32'(k_q)
                           + 32'(kx_q));

    img2col_rom #(.DEPTH(FMAP_DEPTH), .WIDTH(DATA_SIZE)) u_fmap_rom (
        .clk     (clk),
        .rd_en   (enable),
        .addr    (fmap_addr),
        .rd_data (fmap_data)
    );

    img2col_rom #(.DEPTH(WGT_DEPTH), .WIDTH(DATA_SIZE)) u_wgt_rom (
        .clk     (clk),
        .rd_en   (enable),
        .addr    (wgt_addr),
        .rd_data (wgt_data)
    );

    assign fmap_ext = PW'($signed(fmap_data));
    assign wgt_ext  = PW'($signed(wgt_data));
    assign prod_raw = fmap_ext * wgt_ext;

    assign kx_end    = (kx_q == k_q - KERNEL_SIZE'(1));
    assign ky_end    = (ky_q == k_q - KERNEL_SIZE'(1));
    assign ch_end    = (ch_q == c_q - CHANNELS_SIZE'(1));
    assign kn_end    = (kn_q == n_q - KERNEL_NUMS_SIZE'(1));
    assign ox_end    = !origin_can_step(ox_q, s_q, k_q, t_q);
    assign oy_end    = !origin_can_step(oy_q, s_q, k_q, t_q);
    assign tap_first = (ch_q == '0) && (ky_q == '0) && (kx_q == '0);

    // Decided from the live inputs in the LATCH cycle, i.e. the values being captured.
    assign degenerate = (kernel_size == '0) || (channels == '0) || (stride == '0)
                     || (kernel_nums == '0) || (kernel_size > tensor_size);

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        k_d         = k_q;
        c_d         = c_q;
        s_d         = s_q;
        n_d         = n_q;
        kn_d        = kn_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        ch_d        = ch_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        rd_v_d      = rd_v_q;
        rd_first_d  = rd_first_q;
        rd_last_d   = rd_last_q;
        mul_v_d     = mul_v_q;
        mul_first_d = mul_first_q;
        mul_last_d  = mul_last_q;
        acc_last_d  = acc_last_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        o_result_d  = o_result_q;
        w_done_d    = w_done_q;

        if (enable) begin
            rd_v_d      = 1'b0;
            rd_first_d  = 1'b0;
            rd_last_d   = 1'b0;
            mul_v_d     = rd_v_q;
            mul_first_d = rd_first_q;
            mul_last_d  = rd_last_q;
            prod_d      = RESULT_SIZE'(prod_raw);
            acc_last_d  = mul_v_q && mul_last_q;
            if (mul_v_q) begin
                acc_d = mul_first_q ? prod_q : acc_q + prod_q;
            end
            if (acc_last_q) begin
                o_result_d = acc_q;
            end

            case (state_q)
                ST_IDLE: begin
                    state_d = ST_LATCH;
                end
                ST_LATCH: begin
                    t_d      = tensor_size;
                    k_d      = kernel_size;
                    c_d      = channels;
                    s_d      = stride;
                    n_d      = kernel_nums;
                    kn_d     = '0;
                    oy_d     = '0;
                    ox_d     = '0;
                    ch_d     = '0;
                    ky_d     = '0;
                    kx_d     = '0;
                    state_d  = degenerate ? ST_DONE : ST_RUN;
                    w_done_d = degenerate;
                end
                ST_RUN: begin
                    rd_v_d     = 1'b1;
                    rd_first_d = tap_first;
                    rd_last_d  = kx_end && ky_end && ch_end;
                    // Odometer: kx fastest, then ky, c, ox, oy, kernel.
                    if (!kx_end) begin
                        kx_d = kx_q + KERNEL_SIZE'(1);
                    end else begin
                        kx_d = '0;
                        if (!ky_end) begin
                            ky_d = ky_q + KERNEL_SIZE'(1);
                        end else begin
                            ky_d = '0;
                            if (!ch_end) begin
                                ch_d = ch_q + CHANNELS_SIZE'(1);
                            end else begin
                                ch_d = '0;
                                if (!ox_end) begin
                                    ox_d = ox_q + TENSOR_SIZE'(s_q);
                                end else begin
                                    ox_d = '0;
                                    if (!oy_end) begin
                                        oy_d = oy_q + TENSOR_SIZE'(s_q);
                                    end else begin
                                        oy_d = '0;
                                        if (!kn_end) begin
                                            kn_d = kn_q + KERNEL_NUMS_SIZE'(1);
                                        end else begin
                                            kn_d    = '0;
                                            state_d = ST_DRAIN;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!rd_v_q && !mul_v_q && !acc_last_q) begin
                        state_d  = ST_DONE;
                        w_done_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            k_q         <= '0;
            c_q         <= '0;
            s_q         <= '0;
            n_q         <= '0;
            kn_q        <= '0;
            oy_q        <= '0;
            ox_q        <= '0;
            ch_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            rd_v_q      <= 1'b0;
            rd_first_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            mul_v_q     <= 1'b0;
            mul_first_q <= 1'b0;
            mul_last_q  <= 1'b0;
            acc_last_q  <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            o_result_q  <= '0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            k_q         <= k_d;
            c_q         <= c_d;
            s_q         <= s_d;
            n_q         <= n_d;
            kn_q        <= kn_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            ch_q        <= ch_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            rd_v_q      <= rd_v_d;
            rd_first_q  <= rd_first_d;
            rd_last_q   <= rd_last_d;
            mul_v_q     <= mul_v_d;
            mul_first_q <= mul_first_d;
            mul_last_q  <= mul_last_d;
            acc_last_q  <= acc_last_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            o_result_q  <= o_result_d;
            w_done_q    <= w_done_d;
        end
    end

    assign o_result = o_result_q;
    assign dout     = acc_q;
    assign w_done   = w_done_q;

endmodule

// File: tb/tb_img_2col_gemm.sv
// Directed bench for img_2col_gemm: table of configurations with hand-computed
// result sequences, plus stall, config-scramble and mid-run reset sequences.
module tb_img_2col_gemm;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  tensor_size = '0, kernel_size = '0, channels = '0, stride = '0, kernel_nums = '0;
    logic [31:0] o_result, dout;
    logic        w_done;

    always #5 clk = ~clk;

    img_2col_gemm dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .tensor_size (tensor_size),
        .kernel_size (kernel_size),
        .channels    (channels),
        .stride      (stride),
        .kernel_nums (kernel_nums),
        .o_result    (o_result),
        .w_done      (w_done),
        .dout        (dout)
    );

    typedef struct {
        logic [7:0] t, k, c, s, n;
        int f_base, f_step;   // fmap[i] = f_base + f_step*i
        int w_a, w_b;         // weight[0] = w_a, all others = w_b
        int exp_n;
        int exp_r [4];
    } vec_t;

    localparam int NV = 8;
    vec_t        vecs [NV];
    int          vec_done [NV];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_q [$];
    int          done_cycle;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     name, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic load_roms(input int f_base, input int f_step, input int w_a, input int w_b);
        for (int i = 0; i < 64; i++) begin
            dut.u_fmap_rom.mem[i] = 8'(f_base + f_step * i);
            dut.u_wgt_rom.mem[i]  = (i == 0) ? 8'(w_a) : 8'(w_b);
        end
    endtask

    task automatic apply_cfg(input logic [7:0] t, input logic [7:0] k, input logic [7:0] c,
                             input logic [7:0] s, input logic [7:0] n);
        tensor_size = t;
        kernel_size = k;
        channels    = c;
        stride      = s;
        kernel_nums = n;
    endtask

    // Holds reset for two cycles (enable left as is), checking outputs are cleared.
    task automatic do_reset(input string tag);
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("%s_rst_o_result", tag), o_result, 32'd0);
            check($sformatf("%s_rst_dout", tag), dout, 32'd0);
            check($sformatf("%s_rst_w_done", tag), {31'd0, w_done}, 32'd1 - 32'd1);
        end
        enable = 1'b0;
        rstn   = 1'b0;
    endtask

    // Runs until w_done or budget; logs each new o_result value into got_q.
    task automatic run_case(input int stall_at, input int stall_len, input bit scramble,
                            input int budget, input string tag);
        int          cyc;
        logic [31:0] prev, held_dout, held_res;
        got_q.delete();
        done_cycle = -1;
        prev       = o_result;
        held_dout  = '0;
        held_res   = '0;
        cyc        = 0;
        enable     = 1'b1;
        while (cyc < budget && done_cycle < 0) begin
            @(negedge clk);
            cyc++;
            if (o_result !== prev) begin
                got_q.push_back(o_result);
                prev = o_result;
            end
            if (stall_len > 0 && cyc > stall_at && cyc <= stall_at + stall_len) begin
                check($sformatf("%s_stall_dout_c%0d", tag, cyc), dout, held_dout);
                check($sformatf("%s_stall_ores_c%0d", tag, cyc), o_result, held_res);
            end
            if (w_done) done_cycle = cyc;
            if (scramble && cyc == 3) apply_cfg(8'd7, 8'd1, 8'd3, 8'd1, 8'd5);
            if (stall_len > 0 && cyc == stall_at) begin
                enable    = 1'b0;
                held_dout = dout;
                held_res  = o_result;
            end
            if (stall_len > 0 && cyc == stall_at + stall_len) enable = 1'b1;
        end
        enable = 1'b1;
    endtask

    task automatic check_seq(input string tag, input int exp_n, input int exp_r [4]);
        check($sformatf("%s_done_seen", tag), {31'd0, done_cycle >= 0}, 32'd1);
        check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            check($sformatf("%s_res%0d", tag, i),
                  (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, 32'(exp_r[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r026 [4];
        int r027 [4];
        vecs[0] = '{8'd3, 8'd3, 8'd1, 8'd1, 8'd1, 1,   0, 2,  2, 1, '{18, 0, 0, 0}};
        vecs[1] = '{8'd4, 8'd2, 8'd1, 8'd2, 8'd1, 0,   1, 1,  1, 4, '{10, 18, 42, 50}};
        vecs[2] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 127, 0, -1, 2, 2, '{-127, 254, 0, 0}};
        vecs[3] = '{8'd3, 8'd5, 8'd1, 8'd1, 8'd1, 1,   0, 1,  1, 0, '{0, 0, 0, 0}};
        vecs[4] = '{8'd4, 8'd2, 8'd1, 8'd0, 8'd1, 1,   0, 1,  1, 0, '{0, 0, 0, 0}};
        vecs[5] = '{8'd3, 8'd3, 8'd1, 8'd1, 8'd0, 1,   0, 1,  1, 0, '{0, 0, 0, 0}};
        vecs[6] = '{8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 0,   1, 3, -1, 4, '{-52, -56, -64, -68}};
        vecs[7] = '{8'd3, 8'd1, 8'd0, 8'd1, 8'd1, 1,   0, 1,  1, 0, '{0, 0, 0, 0}};
        r026 = '{18, 0, 0, 0};
        r027 = '{10, 18, 42, 50};

        for (int v = 0; v < NV; v++) begin
            string tag;
            int    final_res;
            tag = $sformatf("v%0d", v);
            do_reset(tag);
            load_roms(vecs[v].f_base, vecs[v].f_step, vecs[v].w_a, vecs[v].w_b);
            apply_cfg(vecs[v].t, vecs[v].k, vecs[v].c, vecs[v].s, vecs[v].n);
            run_case(0, 0, 1'b0, 400, tag);
            vec_done[v] = done_cycle;
            check_seq(tag, vecs[v].exp_n, vecs[v].exp_r);
            final_res = (vecs[v].exp_n > 0) ? vecs[v].exp_r[vecs[v].exp_n - 1] : 0;
            check($sformatf("%s_final_dout", tag), dout, 32'(final_res));
            if (vecs[v].exp_n == 0) begin
                check($sformatf("%s_early_done", tag),
                      {31'd0, done_cycle >= 0 && done_cycle <= 3}, 32'd1);
            end
            repeat (3) @(negedge clk);
            check($sformatf("%s_sticky_done", tag), {31'd0, w_done}, 32'd1);
            check($sformatf("%s_held_result", tag), o_result, 32'(final_res));
            $display("vector %0d: T=%0d K=%0d C=%0d S=%0d N=%0d -> %0d results, done at cycle %0d",
                     v, vecs[v].t, vecs[v].k, vecs[v].c, vecs[v].s, vecs[v].n,
                     got_q.size(), done_cycle);
        end

        // Four-cycle enable drop mid-run, inputs scrambled after capture.
        do_reset("stall");
        load_roms(0, 1, 1, 1);
        apply_cfg(8'd4, 8'd2, 8'd1, 8'd2, 8'd1);
        run_case(8, 4, 1'b1, 400, "stall");
        check_seq("stall", 4, r027);
        check("stall_done_delay", 32'(done_cycle), 32'(vec_done[1] + 4));
        $display("stall run: %0d results, done at cycle %0d (unstalled %0d)",
                 got_q.size(), done_cycle, vec_done[1]);

        // Reset in the middle of a run with enable held high, then a fresh run.
        do_reset("pre");
        load_roms(0, 1, 1, 1);
        apply_cfg(8'd4, 8'd2, 8'd1, 8'd2, 8'd1);
        enable = 1'b1;
        repeat (9) @(negedge clk);
        do_reset("mid");
        load_roms(1, 0, 2, 2);
        apply_cfg(8'd3, 8'd3, 8'd1, 8'd1, 8'd1);
        run_case(0, 0, 1'b0, 400, "rerun");
        check_seq("rerun", 1, r026);
        check("rerun_done_cycle", 32'(done_cycle), 32'(vec_done[0]));
        $display("rerun after mid-run reset: %0d results, done at cycle %0d",
                 got_q.size(), done_cycle);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
